peak_frame_buffer: RTL
======================

Name: peak_frame_buffer

Overview:
- Receiving end of the peak-sample stream produced by the acquisition block.
- Collects FRAME_LEN samples per power-line cycle, starting from the rising edge of normal_signal, into a ping-pong RAM.
- Presents each complete frame to the MCU-side read port through a sequential request/valid handshake.
- Sits between the peak acquisition block and the MCU communication logic.

Parameters:
- DATA_W, 16, sample width in bits.
- FRAME_LEN, 128, samples per power-line cycle.
- ADDR_W, 7, log2(FRAME_LEN).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous reset, active-high.
- normal_signal  in  1  power-line square wave; its rising edge starts a frame.
- sample_data  in  DATA_W  sample from the acquisition block.
- sample_valid  in  1  one-cycle strobe, sample_data valid.
- rd_req  in  1  MCU-side request for the next word of the ready frame.
- rd_data  out  DATA_W  read word.
- rd_valid  out  1  rd_data valid; one cycle.
- rd_last  out  1  asserted with rd_valid on word FRAME_LEN-1.
- frame_ready  out  1  level; one complete frame is available for reading.
- overrun_err  out  1  sticky; a completed frame was dropped because no bank was free.
- short_err  out  1  sticky; a sync edge arrived before FRAME_LEN samples were collected.
- err_clr  in  1  clears both sticky error flags.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: all outputs 0; writer in WAIT_SYNC; wr_bank=0; both banks free.
- Edge detect: normal_signal registered once; sync = normal_signal & ~normal_signal_q.
- Writer FSM:
  - WAIT_SYNC: on sync go to FILL, wr_idx=0.
  - FILL: each sample_valid writes RAM[wr_bank][wr_idx], then wr_idx++.
  - When the write of index FRAME_LEN-1 occurs, go to DONE.
  - sync seen in FILL with wr_idx<FRAME_LEN: set short_err, discard partial frame, restart at wr_idx=0 in the same bank.
  - A sample_valid coinciding with that sync is written as index 0, and wr_idx becomes 1.
- DONE (one cycle):
  - If the other bank is free: mark wr_bank full, toggle wr_bank, assert frame_ready next cycle.
  - Otherwise: set overrun_err, keep wr_bank free (frame dropped).
  - Then go to WAIT_SYNC.
  - Samples arriving in DONE or WAIT_SYNC are ignored.
  - sync in DONE is taken as the start of a new frame (go to FILL) after the bank decision is applied.
- Reader:
  - rd_req while frame_ready=1: read RAM[rd_bank][rd_idx]. rd_data/rd_valid appear exactly 1 cycle later; rd_idx++.
  - rd_req while frame_ready=0 is ignored; rd_valid stays 0.
  - Back-to-back rd_req every cycle is supported; throughput is 1 word/cycle.
  - On the rd_req reading word FRAME_LEN-1: rd_last asserts with the corresponding rd_valid. frame_ready deasserts the cycle after that request. rd_bank is released and toggled, and rd_idx wraps to 0.
  - If the other bank is already full at release, frame_ready stays low exactly one cycle, then reasserts.
- Write/read conflicts:
  - Writer and reader never target the same bank.
  - A bank release and a bank-full event in the same cycle are both honoured. Release is evaluated first, so no overrun is flagged.
- Error flags:
  - err_clr clears overrun_err and short_err.
  - A set event in the same cycle as err_clr wins (flag stays 1).
- Reset mid-operation: all frames discarded, flags cleared, return to WAIT_SYNC; any in-flight rd_valid is suppressed.

Optional Feature:
- Macro: PEAK_FRAME_PERIOD_EN.
- Defined:
  - 30-bit counter reset to 0 on each sync, saturating at all-ones, is captured per bank when the next sync arrives.
  - Extra output frame_period[29:0] shows the captured value for the bank currently being read.
  - Value is valid while frame_ready=1; it is 0 if no closing sync has been seen yet.
- Undefined: no counter, no frame_period port.

Decomposition:
- Package peak_frame_pkg:
  - DATA_W, FRAME_LEN, ADDR_W.
  - Writer state enum {WAIT_SYNC, FILL, DONE}.
  - PERIOD_W=30.
- Sub-module peak_frame_dpram:
  - Simple dual-port RAM, depth 2*FRAME_LEN, width DATA_W.
  - One write port, one read port, 1-cycle registered read.
  - Address = {bank, idx}.

Test Plan:
- Nominal frame: sync, then 128 samples valued 0..127 → frame_ready=1; 128 consecutive rd_req return 0..127 with rd_valid; rd_last on value 127; frame_ready low afterwards.
- Short frame: sync, 50 samples, sync, 128 samples valued 0x1000+i → short_err=1; read returns 0x1000..0x107F only.
- Overrun: fill 3 frames (A, B, C) with no reads → A and B readable in order; C dropped; overrun_err=1; err_clr → 0.
- Ping-pong under load: read frame A while frame B fills at 1 sample/200 clk → no overrun; frame_ready low exactly 1 cycle between A's rd_last and B's availability.
- Edge cases:
  - sync coincident with sample_valid=0xABCD → word 0 reads 0xABCD.
  - rd_req with frame_ready=0 → no rd_valid.
  - rst asserted mid-read → all outputs 0, next frame reads correctly.
- PEAK_FRAME_PERIOD_EN: sync period 2,000,000 clk → frame_period=2,000,000 (±1) while frame_ready=1.

Source files
------------

// File: rtl/peak_frame_pkg.sv
// Shared sizes and writer state encoding for the peak-sample frame buffer.
package peak_frame_pkg;
    localparam int DATA_W    = 16;
    localparam int FRAME_LEN = 128;
    localparam int ADDR_W    = 7;
    localparam int PERIOD_W  = 30;

    typedef enum logic [1:0] {
        WAIT_SYNC,
        FILL,
        DONE
    } wr_state_e;
endpackage

// File: rtl/peak_frame_buffer_if.sv
// Acquisition-side and MCU-side signals of the peak frame buffer.
// PEAK_FRAME_PERIOD_EN adds the frame_period readback.
interface peak_frame_buffer_if;
    import peak_frame_pkg::*;

    logic              normal_signal;
    logic [DATA_W-1:0] sample_data;
    logic              sample_valid;
    logic              rd_req;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_last;
    logic              frame_ready;
    logic              overrun_err;
    logic              short_err;
    logic              err_clr;
`ifdef PEAK_FRAME_PERIOD_EN
    logic [PERIOD_W-1:0] frame_period;
`endif

    modport master (
        output normal_signal, sample_data, sample_valid, rd_req, err_clr,
        input  rd_data, rd_valid, rd_last, frame_ready, overrun_err, short_err
`ifdef PEAK_FRAME_PERIOD_EN
        , input frame_period
`endif
    );

    modport slave (
        input  normal_signal, sample_data, sample_valid, rd_req, err_clr,
        output rd_data, rd_valid, rd_last, frame_ready, overrun_err, short_err
`ifdef PEAK_FRAME_PERIOD_EN
        , output frame_period
`endif
    );
endinterface

// File: rtl/peak_frame_dpram.sv
// Two-bank sample store: one write port, one read port with registered read data.
module peak_frame_dpram
    import peak_frame_pkg::*;
(
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W:0]   waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W:0]   raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem [2*FRAME_LEN];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/peak_frame_buffer.sv
// Ping-pong frame capture of peak samples aligned to the power-line sync edge.
// PEAK_FRAME_PERIOD_EN adds a per-bank sync-to-sync period capture.
module peak_frame_buffer
    import peak_frame_pkg::*;
(
    input  logic clk,
    input  logic rst,
    peak_frame_buffer_if.slave bus
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

    wr_state_e         state_q, state_d;
    logic              norm_q, sync;
    logic [ADDR_W-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic              drop_q, drop_d;
    logic [1:0]        full_q, full_d, full_rel;
    logic              frame_ready_q, frame_ready_d;
    logic              rd_valid_q, rd_last_q;
    logic              ovr_q, ovr_d, short_q, short_d, ovr_set, short_set;
    logic              we, rd_fire, rd_wrap;
    logic [ADDR_W:0]   waddr;
    logic [DATA_W-1:0] rdata;

    assign sync    = bus.normal_signal & ~norm_q;
    assign rd_fire = bus.rd_req & frame_ready_q;
    assign rd_wrap = rd_fire & (rd_idx_q == LAST_IDX);

    always_comb begin
        rd_idx_d  = rd_idx_q;
        rd_bank_d = rd_bank_q;
        full_rel  = full_q;
        if (rd_fire) rd_idx_d = rd_idx_q + 1'b1;
        if (rd_wrap) begin
            full_rel[rd_bank_q] = 1'b0;
            rd_bank_d           = ~rd_bank_q;
        end
    end

    // A frame whose bank is still held by the reader when it starts is marked
    // drop: its writes are suppressed and its completion raises overrun.
    always_comb begin
        state_d   = state_q;
        wr_idx_d  = wr_idx_q;
        wr_bank_d = wr_bank_q;
        drop_d    = drop_q;
        full_d    = full_rel;
        ovr_set   = 1'b0;
        short_set = 1'b0;
        we        = 1'b0;
        waddr     = {wr_bank_q, wr_idx_q};
        case (state_q)
            FILL: begin
                if (sync) begin
                    short_set = 1'b1;
                end else if (bus.sample_valid) begin
                    we       = ~drop_q;
                    wr_idx_d = wr_idx_q + 1'b1;
                    if (wr_idx_q == LAST_IDX) state_d = DONE;
                end
            end
            DONE: begin
                if (drop_q) begin
                    ovr_set = 1'b1;
                end else begin
                    full_d[wr_bank_q] = 1'b1;
                    wr_bank_d         = ~wr_bank_q;
                end
                state_d = WAIT_SYNC;
            end
            default: ;
        endcase
        // Every sync opens a frame; a sample on the same cycle becomes index 0.
        if (sync) begin
            state_d  = FILL;
            drop_d   = full_d[wr_bank_d];
            wr_idx_d = '0;
            if (bus.sample_valid) begin
                we       = ~drop_d;
                waddr    = {wr_bank_d, {ADDR_W{1'b0}}};
                wr_idx_d = ADDR_W'(1);
            end
        end
    end

    // The release cycle always forces one low cycle before the next bank shows.
    assign frame_ready_d = rd_wrap ? 1'b0 : full_d[rd_bank_d];
    assign ovr_d         = (ovr_q & ~bus.err_clr) | ovr_set;
    assign short_d       = (short_q & ~bus.err_clr) | short_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= WAIT_SYNC;
            norm_q        <= 1'b0;
            wr_idx_q      <= '0;
            rd_idx_q      <= '0;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            drop_q        <= 1'b0;
            full_q        <= '0;
            frame_ready_q <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_last_q     <= 1'b0;
            ovr_q         <= 1'b0;
            short_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            norm_q        <= bus.normal_signal;
            wr_idx_q      <= wr_idx_d;
            rd_idx_q      <= rd_idx_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            drop_q        <= drop_d;
            full_q        <= full_d;
            frame_ready_q <= frame_ready_d;
            rd_valid_q    <= rd_fire;
            rd_last_q     <= rd_wrap;
            ovr_q         <= ovr_d;
            short_q       <= short_d;
        end
    end

    peak_frame_dpram u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (bus.sample_data),
        .re_i    (rd_fire),
        .raddr_i ({rd_bank_q, rd_idx_q}),
        .rdata_o (rdata)
    );

    assign bus.rd_data     = rd_valid_q ? rdata : '0;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_last     = rd_last_q;
    assign bus.frame_ready = frame_ready_q;
    assign bus.overrun_err = ovr_q;
    assign bus.short_err   = short_q;

`ifdef PEAK_FRAME_PERIOD_EN
    logic [PERIOD_W-1:0]      per_cnt_q;
    logic [1:0][PERIOD_W-1:0] period_q;
    logic                     pend_q, pend_bank_q, commit;

    assign commit = (state_q == DONE) & ~drop_q;

    // A committed frame's period is known only once its closing sync arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            per_cnt_q   <= '0;
            period_q    <= '0;
            pend_q      <= 1'b0;
            pend_bank_q <= 1'b0;
        end else begin
            if (sync)             per_cnt_q <= '0;
            else if (~&per_cnt_q) per_cnt_q <= per_cnt_q + 1'b1;
            if (commit) begin
                period_q[wr_bank_q] <= sync ? per_cnt_q : '0;
                pend_q              <= ~sync;
                pend_bank_q         <= wr_bank_q;
            end else if (sync && pend_q) begin
                period_q[pend_bank_q] <= per_cnt_q;
                pend_q                <= 1'b0;
            end
        end
    end

    assign bus.frame_period = frame_ready_q ? period_q[rd_bank_q] : '0;
`endif
endmodule
